// File: rtl/sysid_regs_if.sv
// Avalon-MM slave bus for the system-identification register block.
// The master modport is the Nios II data-master side, the slave modport is the register file.
interface sysid_regs_if #(
    parameter int DATA_W = 32
);
    logic [2:0]        address;
    logic              read;
    logic              write;
    logic [DATA_W-1:0] writedata;
    logic [DATA_W-1:0] readdata;
    logic              readdatavalid;

    modport master (
        output address, read, write, writedata,
        input  readdata, readdatavalid
    );

    modport slave (
        input  address, read, write, writedata,
        output readdata, readdatavalid
    );
endinterface

// File: rtl/sysid_regs.sv
// System-identification register file: ID, build timestamp, snapshot-read uptime counter,
// scratch words and a control/status word, behind a fixed-latency pipelined read path.
module sysid_regs #(
    parameter int          DATA_W          = 32,
    parameter logic [31:0] ID_VALUE        = 32'h0000_0000,
    parameter logic [31:0] TIMESTAMP_VALUE = 32'h0000_0000,
    parameter int          READ_LATENCY    = 1,
    parameter bit          CNT_EN_RST      = 1'b1
) (
    input  logic         clock,
    input  logic         reset_n,
    sysid_regs_if.slave  bus
);

    localparam int                CNT_W      = 2 * DATA_W;
    localparam logic [CNT_W-1:0]  CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [31:0]       INFO_WORD  = {22'd0, 2'(READ_LATENCY), 8'(DATA_W)};

    localparam logic [2:0] A_ID      = 3'd0;
    localparam logic [2:0] A_TSTAMP  = 3'd1;
    localparam logic [2:0] A_CNT_LO  = 3'd2;
    localparam logic [2:0] A_CNT_HI  = 3'd3;
    localparam logic [2:0] A_SCR0    = 3'd4;
    localparam logic [2:0] A_SCR1    = 3'd5;
    localparam logic [2:0] A_CTRL    = 3'd6;
    localparam logic [2:0] A_INFO    = 3'd7;

    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] snap_q, snap_d;
    logic [DATA_W-1:0] scr0_q, scr0_d;
    logic [DATA_W-1:0] scr1_q, scr1_d;
    logic              en_q, en_d;
    logic              ovf_q, ovf_d;

    logic [READ_LATENCY-1:0] vld_q, vld_d;
    logic [DATA_W-1:0]       dat_q [READ_LATENCY];
    logic [DATA_W-1:0]       dat_d [READ_LATENCY];

    logic [DATA_W-1:0] rd_mux;
    logic              ctrl_wr;

    // Read mux always sees pre-edge state, so a same-cycle write never leaks into the read.
    always_comb begin
        rd_mux = '0;
        case (bus.address)
            A_ID:     rd_mux = ID_VALUE[DATA_W-1:0];
            A_TSTAMP: rd_mux = TIMESTAMP_VALUE[DATA_W-1:0];
            A_CNT_LO: rd_mux = cnt_q[DATA_W-1:0];
            A_CNT_HI: rd_mux = snap_q;
            A_SCR0:   rd_mux = scr0_q;
            A_SCR1:   rd_mux = scr1_q;
            A_CTRL:   begin
                rd_mux[0] = en_q;
                rd_mux[2] = ovf_q;
            end
            A_INFO:   rd_mux = INFO_WORD[DATA_W-1:0];
            default:  rd_mux = '0;
        endcase
    end

    always_comb begin
        ctrl_wr = bus.write && (bus.address == A_CTRL);
        cnt_d   = cnt_q;
        en_d    = en_q;
        ovf_d   = ovf_q;
        scr0_d  = scr0_q;
        scr1_d  = scr1_q;
        snap_d  = snap_q;

        if (bus.write && bus.address == A_SCR0) scr0_d = bus.writedata;
        if (bus.write && bus.address == A_SCR1) scr1_d = bus.writedata;
        if (bus.read && bus.address == A_CNT_LO) snap_d = cnt_q[CNT_W-1:DATA_W];

        if (ctrl_wr) begin
            en_d = bus.writedata[0];
            if (bus.writedata[2]) ovf_d = 1'b0;
        end

        // Clear beats increment; a wrap on the same edge as an OVF clear leaves OVF set.
        if (ctrl_wr && bus.writedata[1]) begin
            cnt_d = '0;
        end else if (en_q) begin
            cnt_d = cnt_q + CNT_ONE;
            if (&cnt_q) ovf_d = 1'b1;
        end
    end

    // Stage data is zeroed on idle cycles so readdata is 0 whenever readdatavalid is 0.
    always_comb begin
        vld_d    = '0;
        vld_d[0] = bus.read;
        dat_d[0] = bus.read ? rd_mux : '0;
        for (int i = 1; i < READ_LATENCY; i++) begin
            vld_d[i] = vld_q[i-1];
            dat_d[i] = dat_q[i-1];
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            cnt_q  <= '0;
            snap_q <= '0;
            scr0_q <= '0;
            scr1_q <= '0;
            en_q   <= CNT_EN_RST;
            ovf_q  <= 1'b0;
            vld_q  <= '0;
            for (int i = 0; i < READ_LATENCY; i++) dat_q[i] <= '0;
        end else begin
            cnt_q  <= cnt_d;
            snap_q <= snap_d;
            scr0_q <= scr0_d;
            scr1_q <= scr1_d;
            en_q   <= en_d;
            ovf_q  <= ovf_d;
            vld_q  <= vld_d;
            for (int i = 0; i < READ_LATENCY; i++) dat_q[i] <= dat_d[i];
        end
    end

    assign bus.readdata      = dat_q[READ_LATENCY-1];
    assign bus.readdatavalid = vld_q[READ_LATENCY-1];

endmodule

// File: tb/tb_sysid_regs.sv
// Two sysid_regs instances (32-bit/latency 2 and 8-bit/latency 3) driven in lockstep and
// compared every cycle against a register-level reference model with a scheduled read queue.
module tb_sysid_regs;

    localparam int          WA       = 32;
    localparam int          LA       = 2;
    localparam int          WB       = 8;
    localparam int          LB       = 3;
    localparam logic [31:0] ID_A     = 32'h5127_DCB1;
    localparam logic [31:0] TS_A     = 32'h6512_0A0B;
    localparam logic [31:0] ID_B     = 32'hA5A5_0F3C;
    localparam logic [31:0] TS_B     = 32'h1234_5678;
    localparam bit          EN_RST_A = 1'b0;
    localparam bit          EN_RST_B = 1'b1;

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;

    logic [2:0]  drv_addr [2];
    logic        drv_rd   [2];
    logic        drv_wr   [2];
    logic [31:0] drv_wd   [2];
    logic        obs_v    [2];
    logic [31:0] obs_d    [2];

    sysid_regs_if #(.DATA_W(WA)) bus_a ();
    sysid_regs_if #(.DATA_W(WB)) bus_b ();

    assign bus_a.address   = drv_addr[0];
    assign bus_a.read      = drv_rd[0];
    assign bus_a.write     = drv_wr[0];
    assign bus_a.writedata = drv_wd[0];
    assign bus_b.address   = drv_addr[1];
    assign bus_b.read      = drv_rd[1];
    assign bus_b.write     = drv_wr[1];
    assign bus_b.writedata = drv_wd[1][WB-1:0];
    assign obs_v[0] = bus_a.readdatavalid;
    assign obs_d[0] = bus_a.readdata;
    assign obs_v[1] = bus_b.readdatavalid;
    assign obs_d[1] = {{(32-WB){1'b0}}, bus_b.readdata};

    sysid_regs #(.DATA_W(WA), .ID_VALUE(ID_A), .TIMESTAMP_VALUE(TS_A),
                 .READ_LATENCY(LA), .CNT_EN_RST(EN_RST_A))
        dut_a (.clock(clock), .reset_n(reset_n), .bus(bus_a.slave));

    sysid_regs #(.DATA_W(WB), .ID_VALUE(ID_B), .TIMESTAMP_VALUE(TS_B),
                 .READ_LATENCY(LB), .CNT_EN_RST(EN_RST_B))
        dut_b (.clock(clock), .reset_n(reset_n), .bus(bus_b.slave));

    // Reference model state, plain integers per instance
    logic [63:0] m_cnt  [2];
    logic [31:0] m_snap [2];
    logic [31:0] m_scr  [2][2];
    bit          m_en   [2];
    bit          m_ovf  [2];
    bit          sched_v [2][16];
    logic [31:0] sched_d [2][16];

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    function automatic int width_of(int i);
        return (i == 0) ? WA : WB;
    endfunction

    function automatic int lat_of(int i);
        return (i == 0) ? LA : LB;
    endfunction

    function automatic logic [31:0] word_mask(int i);
        return (width_of(i) == 32) ? 32'hFFFF_FFFF : ((32'h1 << width_of(i)) - 32'h1);
    endfunction

    function automatic logic [63:0] cnt_mask(int i);
        return (width_of(i) == 32) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'h1 << (2 * width_of(i))) - 64'h1);
    endfunction

    function automatic logic [31:0] model_read(int i, logic [2:0] a);
        logic [31:0] v;
        v = 32'h0;
        case (a)
            3'd0: v = (i == 0) ? ID_A : ID_B;
            3'd1: v = (i == 0) ? TS_A : TS_B;
            3'd2: v = m_cnt[i][31:0];
            3'd3: v = m_snap[i];
            3'd4: v = m_scr[i][0];
            3'd5: v = m_scr[i][1];
            3'd6: v = {29'd0, m_ovf[i], 1'b0, m_en[i]};
            3'd7: v = (32'(lat_of(i)) << 8) | 32'(width_of(i));
            default: v = 32'h0;
        endcase
        return v & word_mask(i);
    endfunction

    // Apply one edge's worth of inputs to the model; e is the index of the coming edge.
    task automatic model_step(int i, int e);
        bit en_old;
        int slot;
        if (!reset_n) begin
            m_cnt[i] = 64'h0;
            m_snap[i] = 32'h0;
            m_scr[i][0] = 32'h0;
            m_scr[i][1] = 32'h0;
            m_ovf[i] = 1'b0;
            m_en[i] = (i == 0) ? EN_RST_A : EN_RST_B;
            for (int k = 0; k < 16; k++) begin
                sched_v[i][k] = 1'b0;
                sched_d[i][k] = 32'h0;
            end
            return;
        end
        en_old = m_en[i];
        if (drv_rd[i]) begin
            slot = (e + lat_of(i) - 1) % 16;
            sched_v[i][slot] = 1'b1;
            sched_d[i][slot] = model_read(i, drv_addr[i]);
            if (drv_addr[i] == 3'd2) m_snap[i] = 32'(m_cnt[i] >> width_of(i)) & word_mask(i);
        end
        if (drv_wr[i]) begin
            case (drv_addr[i])
                3'd4: m_scr[i][0] = drv_wd[i] & word_mask(i);
                3'd5: m_scr[i][1] = drv_wd[i] & word_mask(i);
                3'd6: begin
                    m_en[i] = drv_wd[i][0];
                    if (drv_wd[i][2]) m_ovf[i] = 1'b0;
                end
                default: ;
            endcase
        end
        if (drv_wr[i] && drv_addr[i] == 3'd6 && drv_wd[i][1]) begin
            m_cnt[i] = 64'h0;
        end else if (en_old) begin
            m_cnt[i] = (m_cnt[i] + 64'h1) & cnt_mask(i);
            if (m_cnt[i] == 64'h0) m_ovf[i] = 1'b1;
        end
    endtask

    task automatic check_out(int i);
        int slot;
        logic        ev;
        logic [31:0] ed;
        slot = cyc % 16;
        ev = sched_v[i][slot];
        ed = ev ? sched_d[i][slot] : 32'h0;
        n_checks++;
        assert (obs_v[i] === ev) else begin
            n_errors++;
            $error("FAIL valid[%0d] cyc %0d: observed %b expected %b", i, cyc, obs_v[i], ev);
        end
        n_checks++;
        assert (obs_d[i] === ed) else begin
            n_errors++;
            $error("FAIL rdata[%0d] cyc %0d: observed %h expected %h", i, cyc, obs_d[i], ed);
        end
        sched_v[i][slot] = 1'b0;
    endtask

    task automatic lit(string tag, logic [31:0] o, logic [31:0] x);
        n_checks++;
        assert (o === x) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, o, x);
        end
    endtask

    task automatic set_in(int i, bit r, bit w, logic [2:0] a, logic [31:0] d);
        drv_rd[i] = r;
        drv_wr[i] = w;
        drv_addr[i] = a;
        drv_wd[i] = d;
    endtask

    task automatic idle_in();
        for (int i = 0; i < 2; i++) set_in(i, 1'b0, 1'b0, 3'd0, 32'h0);
    endtask

    task automatic step();
        for (int i = 0; i < 2; i++) model_step(i, cyc + 1);
        @(posedge clock);
        cyc++;
        #1;
        for (int i = 0; i < 2; i++) check_out(i);
        idle_in();
    endtask

    initial begin
        idle_in();
        reset_n = 1'b0;
        repeat (3) step();
        reset_n = 1'b1;

        // ID / TIMESTAMP / INFO back-to-back on the latency-2 instance
        set_in(0, 1, 0, 3'd0, 0); step();
        set_in(0, 1, 0, 3'd1, 0); step();
        lit("id_a", obs_d[0], 32'h5127_DCB1);
        lit("id_a_vld", {31'd0, obs_v[0]}, 32'h1);
        set_in(0, 1, 0, 3'd7, 0); step();
        lit("ts_a", obs_d[0], TS_A);
        step();
        lit("info_a", obs_d[0], 32'h0000_0220);
        step();

        // Same-cycle write and read of SCRATCH0
        set_in(0, 1, 1, 3'd4, 32'hDEAD_BEEF); step();
        set_in(0, 1, 0, 3'd4, 0); step();
        lit("scr0_prewrite", obs_d[0], 32'h0);
        set_in(0, 1, 0, 3'd5, 0); step();
        lit("scr0_postwrite", obs_d[0], 32'hDEAD_BEEF);
        step();
        lit("scr1_untouched", obs_d[0], 32'h0);
        lit("scr1_vld", {31'd0, obs_v[0]}, 32'h1);
        step();

        // Clear with EN=1, then freeze the counter
        set_in(0, 0, 1, 3'd6, 32'h3); step();
        set_in(0, 1, 0, 3'd2, 0); step();
        step();
        lit("cnt_after_clr", obs_d[0], 32'h0);
        set_in(0, 0, 1, 3'd6, 32'h0); step();
        set_in(0, 1, 0, 3'd2, 0); step();
        repeat (10) step();
        set_in(0, 1, 0, 3'd2, 0); step();
        repeat (3) step();

        // 8-bit instance: CNT_HI snapshot across a low-byte carry
        set_in(1, 0, 1, 3'd6, 32'h3); step();
        repeat (255) step();
        set_in(1, 1, 0, 3'd2, 0); step();
        set_in(1, 1, 0, 3'd3, 0); step();
        step();
        lit("cnt_lo_ff", obs_d[1], 32'h0000_00FF);
        step();
        lit("cnt_hi_snap", obs_d[1], 32'h0000_0000);
        set_in(1, 1, 0, 3'd2, 0); step();
        set_in(1, 1, 0, 3'd3, 0); step();
        repeat (4) step();

        // Full 16-bit wrap sets OVF; write-1 clears it
        set_in(1, 0, 1, 3'd6, 32'h3); step();
        repeat (65536) step();
        set_in(1, 1, 0, 3'd6, 0); step();
        set_in(1, 1, 0, 3'd2, 0); step();
        step();
        lit("ovf_set", obs_d[1], 32'h0000_0005);
        step();
        lit("cnt_wrapped", obs_d[1], 32'h0000_0001);
        set_in(1, 0, 1, 3'd6, 32'h5); step();
        set_in(1, 1, 0, 3'd6, 0); step();
        repeat (2) step();
        lit("ovf_cleared", obs_d[1], 32'h0000_0001);
        step();

        // In-flight reads flushed by reset
        set_in(1, 0, 1, 3'd4, 32'h5A); step();
        set_in(0, 1, 0, 3'd0, 0); set_in(1, 1, 0, 3'd0, 0); step();
        set_in(0, 1, 0, 3'd1, 0); set_in(1, 1, 0, 3'd1, 0); step();
        reset_n = 1'b0;
        set_in(0, 1, 1, 3'd4, 32'h77); set_in(1, 1, 1, 3'd7, 32'h77); step();
        lit("flush_vld_b", {31'd0, obs_v[1]}, 32'h0);
        step();
        reset_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            lit("flush_idle_b", {31'd0, obs_v[1]}, 32'h0);
            lit("flush_data_b", obs_d[1], 32'h0);
        end
        set_in(1, 1, 0, 3'd4, 0); step();
        repeat (2) step();
        lit("scr0_after_rst", obs_d[1], 32'h0);
        lit("scr0_after_rst_vld", {31'd0, obs_v[1]}, 32'h1);

        // Randomized traffic on both instances
        for (int n = 0; n < 3000; n++) begin
            for (int i = 0; i < 2; i++) begin
                set_in(i, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) == 0),
                       3'($urandom_range(0, 7)), $urandom);
            end
            reset_n = ($urandom_range(0, 499) != 0);
            step();
        end
        reset_n = 1'b1;
        repeat (5) step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/sysid_regs.md
Name: sysid_regs

Overview:
Parametrised Avalon-MM system-identification slave. It succeeds the single-address, combinational ID/timestamp block with an 8-word register file containing:
- ID and build timestamp words
- a free-running 2×DATA_W uptime counter, read atomically via a snapshot
- writable scratch registers and a control/status word
- a configurable read pipeline with readdatavalid

It sits on the Nios II data master as a slave in the SOPC-generated system.

Parameters:
DATA_W, 32, width of every register and of the data bus (8..32)
ID_VALUE, 32'h0000_0000, system ID word returned at address 0
TIMESTAMP_VALUE, 32'h0000_0000, build timestamp returned at address 1
READ_LATENCY, 1, cycles from read acceptance to readdatavalid (1..3)
CNT_EN_RST, 1, reset value of the counter-enable bit

Ports:
clock  in  1  system clock; all logic on rising edge
reset_n  in  1  synchronous active-low reset, sampled on clock
address  in  3  word address
read  in  1  read request; accepted every cycle, no waitrequest
write  in  1  write request; accepted every cycle
writedata  in  DATA_W  write data
readdata  out  DATA_W  registered read data
readdatavalid  out  1  high for exactly one cycle per accepted read

Behaviour:
Register map (word address):
- 0 ID: ID_VALUE[DATA_W-1:0], read-only.
- 1 TIMESTAMP: TIMESTAMP_VALUE[DATA_W-1:0], read-only.
- 2 CNT_LO: low half of the uptime counter. A read also copies the high half into the snapshot register at the same edge.
- 3 CNT_HI: returns the snapshot register, not the live high half.
- 4 SCRATCH0 and 5 SCRATCH1: read/write, full-word writes.
- 6 CTRL: read/write control and status.
  - bit0 EN: read/write.
  - bit1 CLR: write-1 action; always reads 0.
  - bit2 OVF: sticky; write-1 clears it.
  - Other bits read 0.
- 7 INFO: read-only. {zeros, READ_LATENCY[1:0] at bits 9:8, DATA_W[7:0] at bits 7:0}.

Writes:
- Writes to read-only addresses (0, 1, 2, 3, 7) are ignored.

Uptime counter (2×DATA_W bits):
- Increments by 1 each cycle while EN=1.
- At all ones it wraps to 0 and sets OVF on the same edge.
- A CTRL write with CLR=1 zeroes the counter at that edge. This takes priority over the increment in the same cycle.
- On CLR, EN takes writedata[0].
- A CTRL write with bit2=1 clears OVF. If a wrap occurs on the same edge, the wrap wins and OVF stays 1.

Read timing:
- Read data is the register value before the edge at which the read is accepted. A counter read returns the pre-increment value.
- A read accepted at edge N presents readdata and readdatavalid at edge N+READ_LATENCY.
- Back-to-back reads are fully pipelined, one result per cycle, in order.
- readdata is 0 whenever readdatavalid is 0.

Simultaneous read and write, same cycle:
- The write takes effect.
- The read returns the pre-write value, including for the same address.

Reset (reset_n low at an edge):
- Counter, snapshot, scratch registers and OVF go to 0; EN goes to CNT_EN_RST.
- readdata=0 and readdatavalid=0.
- All in-flight read pipeline stages are flushed: reads accepted before reset never produce readdatavalid.
- read/write requests during reset are ignored.

Test Plan:
1. Reset, then read addr 0, 1, 7 back-to-back with READ_LATENCY=2 and ID_VALUE=32'h5127_DCB1 -> readdatavalid at cycles +2, +3, +4 with 32'h5127_DCB1, TIMESTAMP_VALUE, 32'h0000_0220.
2. Write 32'hDEAD_BEEF to addr 4 while reading addr 4 in the same cycle -> read returns 0. A following read returns 32'hDEAD_BEEF; addr 5 stays 0.
3. With DATA_W=8, force the counter to 16'h00FF-adjacent values by free-run: read addr 2 then addr 3 -> the CNT_HI snapshot matches the high byte at the CNT_LO read edge even though the live high byte increments in between.
4. Write CTRL=32'h3 -> counter reads 0 at the next read, EN=1. Write CTRL=0 -> counter holds value across 10 idle cycles.
5. DATA_W=8, run 65536 cycles from clear -> OVF=1 and the counter wraps to 0. Write CTRL bit2=1 -> OVF reads 0.
6. Issue 3 pipelined reads and assert reset_n=0 one cycle later -> no readdatavalid for those reads. After reset, readdata=0 and SCRATCH0=0.
